// File: rtl/fll_wordcnt_compare.sv
// Word-rate comparator: counts I2S words on the master and local bit clocks and
// drives speedup/slowdown levels from the saturating signed word-count difference.
module fll_wordcnt_compare #(
  parameter int BITS_PER_WORD = 32,
  parameter int DIFF_W        = 8,
  parameter int THRESH        = 2
) (
  input  logic                     CLK_IP_i,
  input  logic                     RST_IP_n_i,
  input  logic                     enable_i,
  input  logic                     bitclk_master_i,
  input  logic                     bitclk_local_i,
  input  logic                     ovf_clr_i,
  output logic                     Interrupt_speedup_o,
  output logic                     Interrupt_slowdown_o,
  output logic                     master_wordcnt_is_ahead_o,
  output logic                     local_wordcnt_is_ahead_o,
  output logic signed [DIFF_W-1:0] word_diff_o,
  output logic                     ovf_o
);

  localparam int CNT_W = $clog2(BITS_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_WORD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic signed [DIFF_W-1:0] DIFF_MAX = {1'b0, {(DIFF_W-1){1'b1}}};
  localparam logic signed [DIFF_W-1:0] DIFF_MIN = {1'b1, {(DIFF_W-1){1'b0}}};
  localparam logic signed [DIFF_W-1:0] DIFF_ONE = DIFF_W'(1);
  localparam logic signed [DIFF_W-1:0] ZERO     = '0;
  localparam logic signed [DIFF_W-1:0] THR_POS  = DIFF_W'(THRESH);
  localparam logic signed [DIFF_W-1:0] THR_NEG  = DIFF_W'(-THRESH);

  typedef enum logic [1:0] {LOCKED, SPEEDUP, SLOWDOWN} state_t;

  // Returns {saturation_event, next_diff}; simultaneous ticks cancel.
  function automatic logic [DIFF_W:0] diff_step(input logic signed [DIFF_W-1:0] d,
                                                input logic up, input logic dn);
    logic                     sat;
    logic signed [DIFF_W-1:0] nxt;
    sat = 1'b0;
    nxt = d;
    if (up && !dn) begin
      if (d == DIFF_MAX) sat = 1'b1;
      else               nxt = d + DIFF_ONE;
    end else if (dn && !up) begin
      if (d == DIFF_MIN) sat = 1'b1;
      else               nxt = d - DIFF_ONE;
    end
    return {sat, nxt};
  endfunction

  logic [1:0]               m_sync_p0, l_sync_p0;
  logic                     m_prev_p0, l_prev_p0;
  logic                     m_rise, l_rise;
  logic [CNT_W-1:0]         m_cnt_p1, l_cnt_p1;
  logic                     m_tick_p1, l_tick_p1;
  logic signed [DIFF_W-1:0] diff_p2;
  logic                     ovf_p2;
  logic [DIFF_W:0]          step;
  state_t                   state_p3;
  logic                     spd_p3, slw_p3, m_ahead_p3, l_ahead_p3;

  // Stage p0: synchronizers and edge registers, free-running regardless of enable_i
  always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
    if (!RST_IP_n_i) begin
      m_sync_p0 <= '0;
      l_sync_p0 <= '0;
      m_prev_p0 <= 1'b0;
      l_prev_p0 <= 1'b0;
    end else begin
      m_sync_p0 <= {m_sync_p0[0], bitclk_master_i};
      l_sync_p0 <= {l_sync_p0[0], bitclk_local_i};
      m_prev_p0 <= m_sync_p0[1];
      l_prev_p0 <= l_sync_p0[1];
    end
  end

  assign m_rise = m_sync_p0[1] & ~m_prev_p0;
  assign l_rise = l_sync_p0[1] & ~l_prev_p0;

  // Stage p1: bit counters and word ticks
  always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
    if (!RST_IP_n_i) begin
      m_cnt_p1  <= '0;
      l_cnt_p1  <= '0;
      m_tick_p1 <= 1'b0;
      l_tick_p1 <= 1'b0;
    end else if (!enable_i) begin
      m_cnt_p1  <= '0;
      l_cnt_p1  <= '0;
      m_tick_p1 <= 1'b0;
      l_tick_p1 <= 1'b0;
    end else begin
      m_tick_p1 <= 1'b0;
      l_tick_p1 <= 1'b0;
      if (m_rise) begin
        if (m_cnt_p1 == LAST_BIT) begin
          m_cnt_p1  <= '0;
          m_tick_p1 <= 1'b1;
        end else begin
          m_cnt_p1 <= m_cnt_p1 + CNT_ONE;
        end
      end
      if (l_rise) begin
        if (l_cnt_p1 == LAST_BIT) begin
          l_cnt_p1  <= '0;
          l_tick_p1 <= 1'b1;
        end else begin
          l_cnt_p1 <= l_cnt_p1 + CNT_ONE;
        end
      end
    end
  end

  assign step = diff_step(diff_p2, m_tick_p1, l_tick_p1);

  // Stage p2: saturating difference and sticky overflow (set beats clear)
  always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
    if (!RST_IP_n_i) begin
      diff_p2 <= '0;
      ovf_p2  <= 1'b0;
    end else if (!enable_i) begin
      diff_p2 <= '0;
      ovf_p2  <= 1'b0;
    end else begin
      diff_p2 <= step[DIFF_W-1:0];
      if (step[DIFF_W])  ovf_p2 <= 1'b1;
      else if (ovf_clr_i) ovf_p2 <= 1'b0;
    end
  end

  // Stage p3: ahead flags and hysteretic interrupt FSM
  always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
    if (!RST_IP_n_i) begin
      state_p3   <= LOCKED;
      spd_p3     <= 1'b0;
      slw_p3     <= 1'b0;
      m_ahead_p3 <= 1'b0;
      l_ahead_p3 <= 1'b0;
    end else if (!enable_i) begin
      state_p3   <= LOCKED;
      spd_p3     <= 1'b0;
      slw_p3     <= 1'b0;
      m_ahead_p3 <= 1'b0;
      l_ahead_p3 <= 1'b0;
    end else begin
      m_ahead_p3 <= (diff_p2 > ZERO);
      l_ahead_p3 <= (diff_p2 < ZERO);
      case (state_p3)
        LOCKED: begin
          if (diff_p2 >= THR_POS) begin
            state_p3 <= SPEEDUP;
            spd_p3   <= 1'b1;
          end else if (diff_p2 <= THR_NEG) begin
            state_p3 <= SLOWDOWN;
            slw_p3   <= 1'b1;
          end
        end
        SPEEDUP: begin
          if (diff_p2 <= ZERO) begin
            state_p3 <= LOCKED;
            spd_p3   <= 1'b0;
          end
        end
        SLOWDOWN: begin
          if (diff_p2 >= ZERO) begin
            state_p3 <= LOCKED;
            slw_p3   <= 1'b0;
          end
        end
        default: begin
          state_p3 <= LOCKED;
          spd_p3   <= 1'b0;
          slw_p3   <= 1'b0;
        end
      endcase
    end
  end

  assign Interrupt_speedup_o       = spd_p3;
  assign Interrupt_slowdown_o      = slw_p3;
  assign master_wordcnt_is_ahead_o = m_ahead_p3;
  assign local_wordcnt_is_ahead_o  = l_ahead_p3;
  assign word_diff_o               = diff_p2;
  assign ovf_o                     = ovf_p2;

endmodule

// File: tb/tb_fll_wordcnt_compare.sv
// Randomized bench for fll_wordcnt_compare against a word-level reference model.
module tb_fll_wordcnt_compare;
  localparam int BPW  = 32;
  localparam int DW   = 4;
  localparam int TH   = 2;
  localparam int DMAX = 7;
  localparam int DMIN = -8;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, bm = 1'b0, bl = 1'b0, clr = 1'b0;
  logic spd, slw, mah, lah, ovf;
  logic signed [DW-1:0] wdiff;

  int n_checks = 0, n_fail = 0;
  int m_bits, l_bits, e_diff, e_st;
  bit e_ovf;

  fll_wordcnt_compare #(.BITS_PER_WORD(BPW), .DIFF_W(DW), .THRESH(TH)) dut (
    .CLK_IP_i(clk), .RST_IP_n_i(rst_n), .enable_i(en),
    .bitclk_master_i(bm), .bitclk_local_i(bl), .ovf_clr_i(clr),
    .Interrupt_speedup_o(spd), .Interrupt_slowdown_o(slw),
    .master_wordcnt_is_ahead_o(mah), .local_wordcnt_is_ahead_o(lah),
    .word_diff_o(wdiff), .ovf_o(ovf));

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run time exceeded, got running required finished");
    $fatal(1);
  end

  task automatic model_clear();
    m_bits = 0; l_bits = 0; e_diff = 0; e_st = 0; e_ovf = 1'b0;
  endtask

  // Word-level model: one rising edge on the selected sides.
  task automatic model_edge(input bit m, input bit l);
    bit mt, lt;
    mt = 1'b0; lt = 1'b0;
    if (m) begin m_bits = (m_bits + 1) % BPW; mt = (m_bits == 0); end
    if (l) begin l_bits = (l_bits + 1) % BPW; lt = (l_bits == 0); end
    if (mt && !lt) begin
      if (e_diff == DMAX) e_ovf = 1'b1; else e_diff = e_diff + 1;
    end else if (lt && !mt) begin
      if (e_diff == DMIN) e_ovf = 1'b1; else e_diff = e_diff - 1;
    end
    if (e_st == 0 && e_diff >= TH) e_st = 1;
    else if (e_st == 0 && e_diff <= -TH) e_st = 2;
    else if (e_st == 1 && e_diff <= 0) e_st = 0;
    else if (e_st == 2 && e_diff >= 0) e_st = 0;
  endtask

  task automatic bit_period(input bit m, input bit l);
    @(negedge clk); bm = m; bl = l;
    repeat (2) @(negedge clk);
    bm = 1'b0; bl = 1'b0;
    @(negedge clk);
    model_edge(m, l);
  endtask

  task automatic edges(input bit m, input bit l, input int n);
    repeat (n) bit_period(m, l);
    repeat (6) @(negedge clk);
  endtask

  task automatic disable_one_cycle();
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({spd, slw, mah, lah, ovf} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 00000", {spd, slw, mah, lah, ovf});
    end
    n_checks++;
    if (wdiff !== 4'sd0) begin
      n_fail++; $display("FAIL reset_diff: got %0d required 0", wdiff);
    end
    @(negedge clk); rst_n = 1'b1; en = 1'b1;
    model_clear();
  endtask

  task automatic test_in_phase();
    edges(1'b1, 1'b1, 10 * BPW);
    n_checks++;
    if (wdiff !== e_diff || e_diff != 0) begin
      n_fail++; $display("FAIL in_phase_diff: got %0d required 0", wdiff);
    end
    n_checks++;
    if ({spd, slw, mah, lah} !== 4'b0) begin
      n_fail++; $display("FAIL in_phase_flags: got %b required 0000", {spd, slw, mah, lah});
    end
  endtask

  task automatic test_one_ahead();
    disable_one_cycle();
    bit_period(1'b1, 1'b0);
    edges(1'b1, 1'b1, BPW - 1);
    n_checks++;
    if (wdiff !== e_diff || e_diff != 1) begin
      n_fail++; $display("FAIL one_ahead_diff: got %0d required 1", wdiff);
    end
    n_checks++;
    if ({mah, lah, spd, slw} !== 4'b1000) begin
      n_fail++; $display("FAIL one_ahead_flags: got %b required 1000", {mah, lah, spd, slw});
    end
    edges(1'b1, 1'b1, 1);
    n_checks++;
    if (wdiff !== e_diff) begin
      n_fail++; $display("FAIL one_ahead_catchup: got %0d required %0d", wdiff, e_diff);
    end
  endtask

  task automatic test_speedup();
    bit found;
    disable_one_cycle();
    edges(1'b1, 1'b0, 2 * BPW - 1);
    n_checks++;
    if (wdiff !== 4'sd1 || spd !== 1'b0) begin
      n_fail++; $display("FAIL speedup_pre: got diff=%0d spd=%b required diff=1 spd=0", wdiff, spd);
    end
    found = 1'b0;
    @(negedge clk); bm = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (wdiff == 4'sd2) found = 1'b1;
    end
    n_checks++;
    if (!found || spd !== 1'b0) begin
      n_fail++; $display("FAIL speedup_same_cycle: got found=%b spd=%b required found=1 spd=0", found, spd);
    end
    @(negedge clk);
    n_checks++;
    if (spd !== 1'b1) begin
      n_fail++; $display("FAIL speedup_next_cycle: got %b required 1", spd);
    end
    bm = 1'b0;
    repeat (2) @(negedge clk);
    model_edge(1'b1, 1'b0);
    edges(1'b0, 1'b1, BPW);
    n_checks++;
    if (wdiff !== e_diff || spd !== 1'b1) begin
      n_fail++; $display("FAIL speedup_hold: got diff=%0d spd=%b required diff=%0d spd=1", wdiff, spd, e_diff);
    end
    edges(1'b0, 1'b1, BPW);
    n_checks++;
    if (wdiff !== 4'sd0 || {spd, slw} !== 2'b00) begin
      n_fail++; $display("FAIL speedup_release: got diff=%0d spd=%b slw=%b required 0 0 0", wdiff, spd, slw);
    end
  endtask

  task automatic test_slowdown();
    for (int w = 1; w <= 2; w++) begin
      edges(1'b0, 1'b1, BPW);
      n_checks++;
      if (wdiff !== e_diff || spd !== 1'b0 || slw !== (e_st == 2) || lah !== 1'b1) begin
        n_fail++;
        $display("FAIL slowdown_w%0d: got diff=%0d spd=%b slw=%b lah=%b required diff=%0d spd=0 slw=%b lah=1",
                 w, wdiff, spd, slw, lah, e_diff, (e_st == 2));
      end
    end
    edges(1'b1, 1'b0, 2 * BPW);
    n_checks++;
    if (wdiff !== 4'sd0 || {spd, slw, lah} !== 3'b000) begin
      n_fail++; $display("FAIL slowdown_release: got diff=%0d flags=%b required 0 000", wdiff, {spd, slw, lah});
    end
  endtask

  task automatic test_saturation();
    disable_one_cycle();
    edges(1'b1, 1'b0, 9 * BPW);
    n_checks++;
    if (wdiff !== 4'sd7 || ovf !== 1'b1 || spd !== 1'b1 || e_diff != 7 || !e_ovf) begin
      n_fail++; $display("FAIL sat_pos: got diff=%0d ovf=%b spd=%b required 7 1 1", wdiff, ovf, spd);
    end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; e_ovf = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ovf !== 1'b0 || wdiff !== 4'sd7) begin
      n_fail++; $display("FAIL sat_clear: got ovf=%b diff=%0d required ovf=0 diff=7", ovf, wdiff);
    end
    edges(1'b1, 1'b0, BPW);
    n_checks++;
    if (ovf !== e_ovf || wdiff !== e_diff) begin
      n_fail++; $display("FAIL sat_reset: got ovf=%b diff=%0d required ovf=%b diff=%0d", ovf, wdiff, e_ovf, e_diff);
    end
  endtask

  task automatic test_disable();
    disable_one_cycle();
    n_checks++;
    if ({spd, slw, mah, lah, ovf} !== 5'b0 || wdiff !== 4'sd0) begin
      n_fail++; $display("FAIL disable_clear: got flags=%b diff=%0d required 00000 0", {spd, slw, mah, lah, ovf}, wdiff);
    end
    edges(1'b1, 1'b0, 10);
    disable_one_cycle();
    edges(1'b1, 1'b0, BPW - 10);
    n_checks++;
    if (wdiff !== e_diff || e_diff != 0) begin
      n_fail++; $display("FAIL disable_partial: got %0d required 0", wdiff);
    end
    edges(1'b1, 1'b0, 10);
    n_checks++;
    if (wdiff !== e_diff || e_diff != 1) begin
      n_fail++; $display("FAIL disable_fullword: got %0d required 1", wdiff);
    end
  endtask

  task automatic test_async_reset();
    edges(1'b1, 1'b0, BPW);
    n_checks++;
    if (spd !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got spd=%b required 1", spd);
    end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({spd, slw, mah, lah, ovf} !== 5'b0 || wdiff !== 4'sd0) begin
      n_fail++; $display("FAIL areset_immediate: got flags=%b diff=%0d required 00000 0", {spd, slw, mah, lah, ovf}, wdiff);
    end
    @(negedge clk); rst_n = 1'b1;
    model_clear();
    repeat (4) @(negedge clk);
    n_checks++;
    if ({spd, slw, mah, lah, ovf} !== 5'b0) begin
      n_fail++; $display("FAIL areset_release: got %b required 00000", {spd, slw, mah, lah, ovf});
    end
  endtask

  task automatic test_random();
    int r, n;
    for (int s = 0; s < 40; s++) begin
      r = $urandom_range(0, 5);
      n = $urandom_range(1, 40);
      if (r == 5) begin
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0; e_ovf = 1'b0;
        repeat (2) @(negedge clk);
      end else if (r == 4) edges(1'b1, 1'b1, n);
      else if (r >= 2) edges(1'b0, 1'b1, n);
      else edges(1'b1, 1'b0, n);
      n_checks++;
      if (wdiff !== e_diff) begin
        n_fail++; $display("FAIL rnd%0d_diff: got %0d required %0d", s, wdiff, e_diff);
      end
      n_checks++;
      if ({spd, slw} !== {e_st == 1, e_st == 2}) begin
        n_fail++; $display("FAIL rnd%0d_irq: got %b required %b", s, {spd, slw}, {e_st == 1, e_st == 2});
      end
      n_checks++;
      if ({mah, lah} !== {e_diff > 0, e_diff < 0}) begin
        n_fail++; $display("FAIL rnd%0d_ahead: got %b required %b", s, {mah, lah}, {e_diff > 0, e_diff < 0});
      end
      n_checks++;
      if (ovf !== e_ovf) begin
        n_fail++; $display("FAIL rnd%0d_ovf: got %b required %b", s, ovf, e_ovf);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_in_phase();
    test_one_ahead();
    test_speedup();
    test_slowdown();
    test_saturation();
    test_disable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
